// File: rtl/cache_arbiter_if.sv
// Bus bundle between the L1I/L1D miss ports, the arbiter and the downstream L2.
// The arbiter attaches through the slave modport; the L1/L2 side uses master.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  l2_rdata, l2_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    output l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output l2_rdata, l2_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    input  l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-way round-robin arbiter sharing one L2 port between the L1I and L1D miss paths,
// with a saturating count of contended arbitration cycles.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_arbiter_if.slave       bus,
  input  logic                 conflict_clear,
  output logic [31:0]          conflict_count
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  localparam logic GntI = 1'b0;
  localparam logic GntD = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [31:0]           conflict_q, conflict_d;
  logic                  i_req, d_req, contended;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [LINE_WIDTH-1:0] wdata_mux;

  assign i_req     = bus.i_pmem_read;
  assign d_req     = bus.d_pmem_read | bus.d_pmem_write;
  assign contended = (state_q == StIdle) && i_req && d_req;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    bus.l2_read     = 1'b0;
    bus.l2_write    = 1'b0;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    addr_mux        = '0;
    wdata_mux       = '0;
    unique case (state_q)
      StIdle: begin
        // On contention the side that did not win last time goes first.
        if (i_req && (!d_req || last_grant_q == GntD)) begin
          state_d      = StGrantI;
          last_grant_d = GntI;
        end else if (d_req) begin
          state_d      = StGrantD;
          last_grant_d = GntD;
        end
      end
      StGrantI: begin
        bus.l2_read     = bus.i_pmem_read;
        addr_mux        = bus.i_pmem_address;
        bus.i_pmem_resp = bus.l2_resp;
        if (bus.l2_resp || !i_req) state_d = StIdle;
      end
      StGrantD: begin
        bus.l2_read     = bus.d_pmem_read;
        bus.l2_write    = bus.d_pmem_write;
        addr_mux        = bus.d_pmem_address;
        wdata_mux       = bus.d_pmem_wdata;
        bus.d_pmem_resp = bus.l2_resp;
        if (bus.l2_resp || !d_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.l2_address   = addr_mux;
  assign bus.l2_wdata     = wdata_mux;
  assign bus.i_pmem_rdata = bus.l2_rdata;
  assign bus.d_pmem_rdata = bus.l2_rdata;

  always_comb begin
    conflict_d = conflict_q;
    if (conflict_clear) begin
      conflict_d = '0;
    end else if (contended && conflict_q != '1) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  assign conflict_count = conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GntD;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: L1 requesters and an L2 responder driven from tasks, with a
// negedge monitor holding a transaction-level arbitration model and a response scoreboard.
`timescale 1ns/1ps
module tb_cache_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conflict_clear = 1'b0;
  logic [31:0] conflict_count;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .conflict_clear (conflict_clear),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
  } req_t;

  req_t exp_i[$];
  req_t exp_d[$];
  logic glog[$];
  int   total = 0;
  int   bad = 0;
  logic l2_auto = 1'b1;
  int   l2_min = 3;
  int   l2_max = 3;
  int   stray_seq = 0;
  int   preload_seq = 0;
  int   n;

  function automatic logic [LW-1:0] pattern(input logic [AW-1:0] a);
    return {4{a ^ 32'h5A5A_0F0F, ~a}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [15:0] glog_pack();
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < glog.size() && k < 8; k++) b[k] = glog[k];
    return {8'(glog.size()), b};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_i();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = $urandom() | 32'h1;
  endtask

  task automatic idle_d();
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = $urandom() | 32'h1;
    bus.d_pmem_wdata   = rand_line();
  endtask

  // Present a request, wait for its resp, return just after the following clock edge
  // with the request still driven so a caller can chain a back-to-back request.
  task automatic issue_i(input logic [AW-1:0] addr, output int waited);
    req_t e;
    e.addr = addr; e.rd = 1'b1; e.wr = 1'b0; e.wdata = '0;
    exp_i.push_back(e);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = addr;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!bus.i_pmem_resp && waited < 300);
    chk("i_resp_timeout", bus.i_pmem_resp, 1);
    @(posedge clk); #1;
  endtask

  task automatic issue_d(input logic [AW-1:0] addr, input logic rd, input logic wr,
                         input logic [LW-1:0] wdata, output int waited);
    req_t e;
    e.addr = addr; e.rd = rd; e.wr = wr; e.wdata = wdata;
    exp_d.push_back(e);
    bus.d_pmem_read    = rd;
    bus.d_pmem_write   = wr;
    bus.d_pmem_address = addr;
    bus.d_pmem_wdata   = wdata;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!bus.d_pmem_resp && waited < 300);
    chk("d_resp_timeout", bus.d_pmem_resp, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {bus.l2_read, bus.l2_write, bus.i_pmem_resp, bus.d_pmem_resp,
                    bus.l2_address}, 0);
    chk("rst_wdata", bus.l2_wdata, 0);
    chk("rst_cnt", conflict_count, 0);
    idle_i();
    idle_d();
    conflict_clear = 1'b0;
    exp_i.delete();
    exp_d.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic pair(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    fork
      begin int w; issue_i(ia, w); idle_i(); end
      begin int w; issue_d(da, 1'b0, 1'b1, rand_line(), w); idle_d(); end
    join
  endtask

  // L2 responder: fixed or random latency measured from the first granted cycle.
  initial begin : l2_model
    logic [AW-1:0] a;
    int            stray_seen;
    stray_seen     = 0;
    bus.l2_resp    = 1'b0;
    bus.l2_rdata   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && l2_auto && (bus.l2_read || bus.l2_write)) begin
        a = bus.l2_address;
        repeat ($urandom_range(l2_max, l2_min)) @(posedge clk);
        #1;
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = pattern(a);
        @(posedge clk); #1;
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = rand_line();
      end else if (rst_n && stray_seq != stray_seen) begin
        stray_seen = stray_seq;
        @(posedge clk); #1;
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = pattern(32'hFFFF_0000);
        @(posedge clk); #1;
        bus.l2_resp  = 1'b0;
      end
    end
  end

  // Monitor: per-cycle routing check against the expected grant holder, response
  // scoreboard, grant-order log and contention counter model.
  initial begin : monitor
    logic ir, dr, act, m_busy, m_side, m_last, prev_active;
    logic [31:0] m_cnt;
    int   seen_preload;
    req_t e;
    m_busy = 1'b0; m_side = 1'b0; m_last = 1'b1; m_cnt = '0; prev_active = 1'b0;
    seen_preload = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_last = 1'b1; m_cnt = '0; prev_active = 1'b0;
      end else begin
        if (preload_seq != seen_preload) begin
          seen_preload = preload_seq;
          m_cnt = 32'hFFFF_FFFE;
        end
        ir = bus.i_pmem_read;
        dr = bus.d_pmem_read | bus.d_pmem_write;
        chk("i_rdata_mirror", bus.i_pmem_rdata, bus.l2_rdata);
        chk("d_rdata_mirror", bus.d_pmem_rdata, bus.l2_rdata);
        chk("conflict_count", conflict_count, m_cnt);
        if (!m_busy) begin
          chk("idle_ctl", {bus.l2_read, bus.l2_write, bus.i_pmem_resp, bus.d_pmem_resp,
                           bus.l2_address}, 0);
          chk("idle_wdata", bus.l2_wdata, 0);
        end else if (!m_side) begin
          chk("grant_i_ctl", {bus.l2_read, bus.l2_write, bus.i_pmem_resp, bus.d_pmem_resp,
                              bus.l2_address},
              {ir, 1'b0, bus.l2_resp, 1'b0, bus.i_pmem_address});
          chk("grant_i_wdata", bus.l2_wdata, 0);
        end else begin
          chk("grant_d_ctl", {bus.l2_read, bus.l2_write, bus.i_pmem_resp, bus.d_pmem_resp,
                              bus.l2_address},
              {bus.d_pmem_read, bus.d_pmem_write, 1'b0, bus.l2_resp, bus.d_pmem_address});
          chk("grant_d_wdata", bus.l2_wdata, bus.d_pmem_wdata);
        end
        if (bus.i_pmem_resp) begin
          if (exp_i.size() == 0) chk("i_resp_unexpected", bus.i_pmem_resp, 0);
          else begin
            e = exp_i.pop_front();
            chk("i_resp_data", bus.i_pmem_rdata, pattern(e.addr));
            chk("i_resp_addr", bus.l2_address, e.addr);
          end
        end
        if (bus.d_pmem_resp) begin
          if (exp_d.size() == 0) chk("d_resp_unexpected", bus.d_pmem_resp, 0);
          else begin
            e = exp_d.pop_front();
            chk("d_resp_data", bus.d_pmem_rdata, pattern(e.addr));
            chk("d_resp_req", {bus.l2_read, bus.l2_write, bus.l2_address},
                {e.rd, e.wr, e.addr});
            if (e.wr) chk("d_resp_wdata", bus.l2_wdata, e.wdata);
          end
        end
        act = bus.l2_read | bus.l2_write;
        if (act && !prev_active) glog.push_back(bus.l2_address[AW-1]);
        prev_active = act;
        // Model the effect of the coming edge.
        if (conflict_clear) m_cnt = '0;
        else if (!m_busy && ir && dr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (!m_busy) begin
          if (ir && dr) m_side = ~m_last;
          else m_side = dr;
          if (ir || dr) begin
            m_busy = 1'b1;
            m_last = m_side;
          end
        end else if (bus.l2_resp || !(m_side ? dr : ir)) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [AW-1:0] a;
    logic          rd, wr;
    int            r, gap;
    idle_i();
    idle_d();
    do_reset();

    // Single I miss, L2 latency 3.
    issue_i(32'h0000_1000, n);
    idle_i();
    chk("single_i_latency", n, 5);
    chk("single_i_grants", glog_pack(), {8'd1, 8'b0});
    repeat (2) @(posedge clk);
    #1;
    // Stray L2 resp while idle must be ignored.
    stray_seq++;
    repeat (4) @(posedge clk);
    #1;

    // Contention after reset: I first, then D writeback.
    do_reset();
    l2_min = 1; l2_max = 3;
    pair(32'h0000_1000, 32'h8000_2000);
    chk("contend_order", glog_pack(), {8'd2, 8'b10});
    chk("contend_cnt", conflict_count, 1);

    // Round robin under continuous contention.
    do_reset();
    fork
      begin issue_i(32'h0000_0100, n); issue_i(32'h0000_0200, n); issue_i(32'h0000_0300, n);
            idle_i(); end
      begin issue_d(32'h8000_0100, 1'b1, 1'b0, '0, n); issue_d(32'h8000_0200, 1'b1, 1'b0, '0, n);
            idle_d(); end
    join
    chk("rr_order", glog_pack(), {8'd5, 8'b01010});
    chk("rr_cnt", conflict_count, 4);

    // Abandoned D read.
    do_reset();
    l2_auto = 1'b0;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h8000_3000;
    repeat (2) @(posedge clk);
    #1;
    idle_d();
    @(negedge clk);
    chk("abandon_l2_read", bus.l2_read, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abandon_idle", {bus.l2_read, bus.d_pmem_resp, bus.l2_address}, 0);
    l2_auto = 1'b1;
    @(posedge clk); #1;
    issue_i(32'h0000_3000, n);
    idle_i();

    // Reset in the middle of a D grant.
    do_reset();
    pair(32'h0000_4000, 32'h8000_4000);
    l2_auto = 1'b0;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h8000_5000;
    bus.d_pmem_wdata   = rand_line();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    l2_auto = 1'b1;
    pair(32'h0000_6000, 32'h8000_6000);
    chk("post_rst_order", glog_pack(), {8'd2, 8'b10});
    chk("post_rst_cnt", conflict_count, 1);

    // Saturation and clear.
    do_reset();
    force dut.conflict_q = 32'hFFFF_FFFE;
    preload_seq++;
    #1;
    release dut.conflict_q;
    pair(32'h0000_7000, 32'h8000_7000);
    chk("sat_reach", conflict_count, 32'hFFFF_FFFF);
    pair(32'h0000_7100, 32'h8000_7100);
    chk("sat_hold", conflict_count, 32'hFFFF_FFFF);
    conflict_clear = 1'b1;
    pair(32'h0000_7200, 32'h8000_7200);
    conflict_clear = 1'b0;
    chk("clear_prio", conflict_count, 0);

    // Randomized traffic.
    do_reset();
    l2_min = 1; l2_max = 3;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          gap = $urandom_range(0, 3);
          if (gap != 0) begin
            idle_i();
            repeat (gap) @(posedge clk);
            #1;
          end
          a = $urandom();
          a[AW-1] = 1'b0;
          issue_i(a, n);
        end
        idle_i();
      end
      begin
        for (int k = 0; k < 40; k++) begin
          gap = $urandom_range(0, 3);
          if (gap != 0) begin
            idle_d();
            repeat (gap) @(posedge clk);
            #1;
          end
          a = $urandom();
          a[AW-1] = 1'b1;
          r  = $urandom_range(0, 9);
          rd = (r < 5) || (r == 9);
          wr = (r >= 5);
          issue_d(a, rd, wr, rand_line(), n);
        end
        idle_d();
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("random_drained", exp_i.size() + exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
